// File: rtl/mesh_command_sequencer_if.sv
// Host-side command push channel for the mesh command sequencer.
interface mesh_command_sequencer_if #(
  parameter int unsigned REPEAT_W = 8
) ();
  logic                cmd_valid;
  logic [2:0]          cmd_op;
  logic [REPEAT_W-1:0] cmd_repeat;
  logic                cmd_ready;

  modport master (output cmd_valid, cmd_op, cmd_repeat, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_repeat, output cmd_ready);
endinterface

// File: rtl/mesh_command_sequencer.sv
// Queues host commands and broadcasts each one to the PE mesh, waiting for every
// cell to report ready before advancing; repeats commands and traps on timeout.
module mesh_command_sequencer #(
  parameter int unsigned NUM_PE     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned REPEAT_W   = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  mesh_command_sequencer_if.slave host,
  output logic [2:0]           command_to_execute,
  output logic                 ack,
  input  logic [NUM_PE-1:0]    pe_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  input  logic                 error_clear,
  output logic [15:0]          issue_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 3 + REPEAT_W;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERROR} state_t;

  state_t              state;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, count_nxt;
  logic [2:0]          op;
  logic [REPEAT_W-1:0] rep;
  logic [NUM_PE-1:0]   seen, seen_all;
  logic [TW-1:0]       tcnt;
  logic [EW-1:0]       head;
  logic                empty, push, pop, flush, complete, to_error, idle_nxt;

  assign head = mem[rd_ptr];

  // Handshake and queue-occupancy decode shared by the FSM and registered flags
  always_comb begin
    empty     = (count == '0);
    seen_all  = seen | pe_ready;
    complete  = (state == WAIT) && (&seen_all);
    to_error  = (state == WAIT) && !complete && (tcnt == TW'(TIMEOUT - 1));
    pop       = ((state == IDLE) || (complete && (rep == '0))) && !empty;
    flush     = (state == ERROR) && error_clear;
    push      = host.cmd_valid && host.cmd_ready;
    count_nxt = flush ? '0 : (count + CW'(push) - CW'(pop));
    idle_nxt  = ((state == IDLE) && empty) || (complete && (rep == '0) && empty) || flush;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {host.cmd_op, host.cmd_repeat};
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      op                 <= '0;
      rep                <= '0;
      seen               <= '0;
      tcnt               <= '0;
      command_to_execute <= '0;
      ack                <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      host.cmd_ready     <= 1'b1;
      issue_count        <= '0;
    end else begin
      done  <= 1'b0;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      busy           <= !idle_nxt || (count_nxt != '0);
      host.cmd_ready <= !to_error && !((state == ERROR) && !error_clear) &&
                        (count_nxt != CW'(FIFO_DEPTH));

      case (state)
        IDLE: begin
          if (!empty) begin
            op                 <= head[EW-1 -: 3];
            rep                <= head[REPEAT_W-1:0];
            command_to_execute <= head[EW-1 -: 3];
            ack                <= 1'b0;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          ack   <= 1'b1;
          seen  <= '0;
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          seen <= seen_all;
          tcnt <= tcnt + TW'(1);
          // Completion takes priority over a timeout landing on the same cycle
          if (complete) begin
            issue_count <= issue_count + 16'd1;
            if (rep != '0) begin
              rep   <= rep - REPEAT_W'(1);
              ack   <= 1'b0;
              state <= ISSUE;
            end else if (!empty) begin
              op                 <= head[EW-1 -: 3];
              rep                <= head[REPEAT_W-1:0];
              command_to_execute <= head[EW-1 -: 3];
              ack                <= 1'b0;
              state              <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end else if (to_error) begin
            error <= 1'b1;
            state <= ERROR;
          end
        end
        ERROR: begin
          if (error_clear) begin
            error <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_command_sequencer.sv
// Scoreboard bench: expected broadcast opcodes are queued at push time and
// checked in order whenever the sequencer drops ack.
module tb_mesh_command_sequencer;
  localparam int unsigned NUM_PE     = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned REPEAT_W   = 8;
  localparam int unsigned TIMEOUT    = 10;

  logic              CLK = 1'b0;
  logic              reset_n;
  logic [2:0]        command_to_execute;
  logic              ack, busy, done, error, error_clear;
  logic [NUM_PE-1:0] pe_ready = '0;
  logic [15:0]       issue_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int wcyc      = 0;
  int mode      = 0;
  int err_stamp = -1;
  logic [2:0] sb[$];
  logic [2:0] exp_op;
  int issue_stamps[$];
  int done_stamps[$];

  always #5 CLK = ~CLK;

  mesh_command_sequencer_if #(.REPEAT_W(REPEAT_W)) host ();

  mesh_command_sequencer #(
    .NUM_PE(NUM_PE), .FIFO_DEPTH(FIFO_DEPTH), .REPEAT_W(REPEAT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .host(host),
    .command_to_execute(command_to_execute), .ack(ack), .pe_ready(pe_ready),
    .busy(busy), .done(done), .error(error), .error_clear(error_clear),
    .issue_count(issue_count)
  );

  // Cell model: mode 0 all ready in WAIT cycle 1, 1 staggered, 2 bit0 stuck, 3 stalled, 4 always ready
  always @(posedge CLK) begin
    #1;
    if (ack === 1'b0) wcyc = 0;
    else if (wcyc < 100000) wcyc = wcyc + 1;
    case (mode)
      0: pe_ready = (wcyc == 1) ? '1 : '0;
      1: for (int i = 0; i < int'(NUM_PE); i++) pe_ready[i] = (wcyc == 2 * i + 1);
      2: pe_ready = (wcyc == 1) ? {{(NUM_PE-1){1'b1}}, 1'b0} : '0;
      4: pe_ready = '1;
      default: pe_ready = '0;
    endcase
  end

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (reset_n === 1'b1) begin
      cyc = cyc + 1;
      if (ack === 1'b0) begin
        issue_stamps.push_back(cyc);
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_issue: cmd=%0d issued with no expected entry", command_to_execute);
        end else begin
          exp_op = sb.pop_front();
          if (command_to_execute !== exp_op)
            $display("FAIL issue_order: got cmd=%0d expected %0d", command_to_execute, exp_op);
          else pass_cnt++;
        end
      end
      if (done === 1'b1) done_stamps.push_back(cyc);
      if (error === 1'b1 && err_stamp < 0) err_stamp = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_reset();
    reset_n = 1'b0;
    host.cmd_valid = 1'b0; host.cmd_op = '0; host.cmd_repeat = '0;
    error_clear = 1'b0; mode = 0;
    sb.delete(); issue_stamps.delete(); done_stamps.delete();
    err_stamp = -1; cyc = 0;
    repeat (2) @(posedge CLK);
    #1 reset_n = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] rep, output bit accepted);
    host.cmd_valid = 1'b1; host.cmd_op = op; host.cmd_repeat = rep;
    accepted = host.cmd_ready;
    if (accepted) for (int k = 0; k <= int'(rep); k++) sb.push_back(op);
    @(posedge CLK); #1;
    host.cmd_valid = 1'b0;
  endtask

  // sel 0 waits for done, sel 1 for error
  task automatic wait_for(input int sel, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK); #1;
      if ((sel == 0 && done === 1'b1) || (sel == 1 && error === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (ack !== 1'b1) $display("FAIL reset_ack: got %b want 1", ack); else pass_cnt++;
    total_cnt++; if (command_to_execute !== 3'd0) $display("FAIL reset_cmd: got %0d want 0", command_to_execute); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else pass_cnt++;
    total_cnt++; if (issue_count !== 16'd0) $display("FAIL reset_issue_count: got %0d want 0", issue_count); else pass_cnt++;
    total_cnt++; if (host.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", host.cmd_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_single_issue();
    bit acc, ok;
    int lat;
    do_reset();
    mode = 0;
    push_cmd(3'b001, 8'd0, acc);
    wait_for(0, 50, ok);
    repeat (3) @(posedge CLK); #1;
    total_cnt++; if (!ok) $display("FAIL single_done_wait: got timeout want done"); else pass_cnt++;
    total_cnt++; if (issue_stamps.size() != 1) $display("FAIL single_ack_pulses: got %0d want 1", issue_stamps.size()); else pass_cnt++;
    lat = (issue_stamps.size() > 0 && done_stamps.size() > 0) ? done_stamps[0] - issue_stamps[0] : -1;
    total_cnt++; if (lat != 2) $display("FAIL single_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (done_stamps.size() != 1) $display("FAIL single_done_pulses: got %0d want 1", done_stamps.size()); else pass_cnt++;
    total_cnt++; if (issue_count !== 16'd1) $display("FAIL single_issue_count: got %0d want 1", issue_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_repeat();
    bit acc, ok;
    do_reset();
    mode = 0;
    push_cmd(3'b011, 8'd3, acc);
    wait_for(0, 100, ok);
    repeat (3) @(posedge CLK); #1;
    total_cnt++; if (!ok) $display("FAIL repeat_done_wait: got timeout want done"); else pass_cnt++;
    total_cnt++; if (issue_stamps.size() != 4) $display("FAIL repeat_ack_pulses: got %0d want 4", issue_stamps.size()); else pass_cnt++;
    for (int i = 1; i < issue_stamps.size(); i++) begin
      total_cnt++;
      if (issue_stamps[i] - issue_stamps[i-1] != 2)
        $display("FAIL repeat_spacing: got %0d want 2 at pulse %0d", issue_stamps[i] - issue_stamps[i-1], i);
      else pass_cnt++;
    end
    total_cnt++; if (issue_count !== 16'd4) $display("FAIL repeat_issue_count: got %0d want 4", issue_count); else pass_cnt++;
    total_cnt++; if (done_stamps.size() != 1) $display("FAIL repeat_done_pulses: got %0d want 1", done_stamps.size()); else pass_cnt++;
  endtask

  task automatic test_staggered();
    bit acc, ok;
    int lat;
    do_reset();
    mode = 1;
    push_cmd(3'b000, 8'd0, acc);
    wait_for(0, 50, ok);
    total_cnt++; if (!ok) $display("FAIL stagger_done_wait: got timeout want done"); else pass_cnt++;
    lat = (issue_stamps.size() > 0 && done_stamps.size() > 0) ? done_stamps[0] - issue_stamps[0] : -1;
    total_cnt++; if (lat != 8) $display("FAIL stagger_latency: got %0d want 8", lat); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL stagger_error: got %b want 0", error); else pass_cnt++;
    total_cnt++; if (issue_count !== 16'd1) $display("FAIL stagger_issue_count: got %0d want 1", issue_count); else pass_cnt++;
  endtask

  task automatic test_full_queue();
    bit acc, ok;
    int n_acc = 0;
    do_reset();
    mode = 3;
    push_cmd(3'b111, 8'd0, acc);
    for (int i = 0; i < 9; i++) begin
      push_cmd(3'(i), 8'd0, acc);
      if (acc) n_acc++;
      if (i == 8) begin
        total_cnt++; if (acc) $display("FAIL full_ninth_rejected: got accepted want rejected"); else pass_cnt++;
      end
    end
    mode = 4;
    total_cnt++; if (n_acc != 8) $display("FAIL full_accepted: got %0d want 8", n_acc); else pass_cnt++;
    wait_for(0, 300, ok);
    total_cnt++; if (!ok) $display("FAIL full_done_wait: got timeout want done"); else pass_cnt++;
    total_cnt++; if (issue_count !== 16'd9) $display("FAIL full_issue_count: got %0d want 9", issue_count); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL full_sb_drained: got %0d left want 0", sb.size()); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL full_error: got %b want 0", error); else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit acc, ok;
    int lat;
    do_reset();
    mode = 2;
    push_cmd(3'b101, 8'd0, acc);
    push_cmd(3'b001, 8'd0, acc);
    push_cmd(3'b010, 8'd0, acc);
    wait_for(1, 60, ok);
    total_cnt++; if (!ok) $display("FAIL timeout_error_wait: got no error want error"); else pass_cnt++;
    lat = (issue_stamps.size() > 0 && err_stamp >= 0) ? err_stamp - issue_stamps[0] : -1;
    total_cnt++; if (lat != 11) $display("FAIL timeout_latency: got %0d want 11", lat); else pass_cnt++;
    repeat (3) @(posedge CLK); #1;
    total_cnt++; if (ack !== 1'b1) $display("FAIL timeout_ack: got %b want 1", ack); else pass_cnt++;
    total_cnt++; if (host.cmd_ready !== 1'b0) $display("FAIL timeout_cmd_ready: got %b want 0", host.cmd_ready); else pass_cnt++;
    total_cnt++; if (issue_stamps.size() != 1) $display("FAIL timeout_issues: got %0d want 1", issue_stamps.size()); else pass_cnt++;
    sb.delete();
    error_clear = 1'b1;
    @(posedge CLK); #1;
    error_clear = 1'b0;
    total_cnt++; if (error !== 1'b0) $display("FAIL clear_error: got %b want 0", error); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL clear_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (host.cmd_ready !== 1'b1) $display("FAIL clear_cmd_ready: got %b want 1", host.cmd_ready); else pass_cnt++;
    mode = 4;
    repeat (10) @(posedge CLK); #1;
    total_cnt++; if (issue_stamps.size() != 1) $display("FAIL clear_flushed: got %0d issues want 1", issue_stamps.size()); else pass_cnt++;
    total_cnt++; if (done_stamps.size() != 0) $display("FAIL clear_no_done: got %0d pulses want 0", done_stamps.size()); else pass_cnt++;
    total_cnt++; if (issue_count !== 16'd0) $display("FAIL clear_issue_count: got %0d want 0", issue_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit acc;
    do_reset();
    mode = 3;
    push_cmd(3'b110, 8'd0, acc);
    push_cmd(3'b011, 8'd0, acc);
    push_cmd(3'b100, 8'd0, acc);
    push_cmd(3'b111, 8'd0, acc);
    repeat (2) @(posedge CLK); #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (command_to_execute !== 3'b110) $display("FAIL midrst_cmd_before: got %0d want 6", command_to_execute); else pass_cnt++;
    sb.delete(); issue_stamps.delete();
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (command_to_execute !== 3'd0) $display("FAIL midrst_cmd: got %0d want 0", command_to_execute); else pass_cnt++;
    total_cnt++; if (ack !== 1'b1) $display("FAIL midrst_ack: got %b want 1", ack); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (host.cmd_ready !== 1'b1) $display("FAIL midrst_cmd_ready: got %b want 1", host.cmd_ready); else pass_cnt++;
    @(posedge CLK); #1;
    reset_n = 1'b1;
    mode = 4;
    repeat (20) @(posedge CLK); #1;
    total_cnt++; if (issue_stamps.size() != 0) $display("FAIL midrst_no_issue: got %0d issues want 0", issue_stamps.size()); else pass_cnt++;
    total_cnt++; if (issue_count !== 16'd0) $display("FAIL midrst_issue_count: got %0d want 0", issue_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy_after: got %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_repeat();
    test_staggered();
    test_full_queue();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
